// File: rtl/mandelbrot_cfg_pkg.sv
// Shared definitions for the Mandelbrot configuration link: payload width,
// field positions inside the configuration word, and the receiver FSM states.
package mandelbrot_cfg_pkg;

  localparam int CFG_WIDTH = 57;

  // Field placement inside cfg_out (LSB position / width)
  localparam int CR_OFFSET_LSB  = 0;
  localparam int CR_OFFSET_W    = 16;
  localparam int CI_OFFSET_LSB  = 16;
  localparam int CI_OFFSET_W    = 16;
  localparam int SCALING_LSB    = 32;
  localparam int SCALING_W      = 7;
  localparam int CTR_SELECT_LSB = 39;
  localparam int CTR_SELECT_W   = 3;
  localparam int MAX_CTR_LSB    = 42;
  localparam int MAX_CTR_W      = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } rx_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous pin. level_o is the last
// stage; rise/fall compare the last stage against the stage before it, so
// an edge is flagged one cycle before it appears on level_o.
module sync_edge_detect #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First stage samples the raw asynchronous pin
        always_ff @(posedge clk) begin
          if (rst) sync_q[gi] <= 1'b0;
          else     sync_q[gi] <= async_i;
        end
      end else begin : g_rest
        // Later stages shift the value along the chain
        always_ff @(posedge clk) begin
          if (rst) sync_q[gi] <= 1'b0;
          else     sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  assign level_o = sync_q[STAGES-1];
  assign rise_o  =  sync_q[STAGES-2] & ~sync_q[STAGES-1];
  assign fall_o  = ~sync_q[STAGES-2] &  sync_q[STAGES-1];

endmodule

// File: rtl/cfg_serial_rx.sv
// Serial configuration receiver (sen/sclk/sdata, LSB first). Bits are
// shifted into a shadow register and copied to cfg_out only when a frame
// ends with exactly the expected length, followed by a one-cycle start.
// Optional feature macro: CFG_PARITY_EN adds a trailing even-parity bit.
module cfg_serial_rx
  import mandelbrot_cfg_pkg::*;
#(
  parameter int CFG_WIDTH   = mandelbrot_cfg_pkg::CFG_WIDTH,
  parameter int SYNC_STAGES = 3   // must be 3 or more
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sen_in,
  input  logic                 sclk_in,
  input  logic                 sdata_in,
  output logic [CFG_WIDTH-1:0] cfg_out,
  output logic                 cfg_valid,
  output logic                 start,
  output logic                 frame_error,
  output logic                 busy
);

`ifdef CFG_PARITY_EN
  localparam int FRAME_BITS = CFG_WIDTH + 1;
`else
  localparam int FRAME_BITS = CFG_WIDTH;
`endif
  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam int SET_W = $clog2(SYNC_STAGES + 1);
  localparam logic [SET_W-1:0] SETTLE_DONE = SET_W'(SYNC_STAGES);

  logic s_sen, sen_rise, sen_fall;
  logic sclk_rise, s_sdata;
  logic unused_sclk_level, unused_sclk_fall;
  logic unused_sdata_rise, unused_sdata_fall;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sen (
    .clk     (clk),
    .rst     (rst),
    .async_i (sen_in),
    .level_o (s_sen),
    .rise_o  (sen_rise),
    .fall_o  (sen_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .async_i (sclk_in),
    .level_o (unused_sclk_level),
    .rise_o  (sclk_rise),
    .fall_o  (unused_sclk_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk     (clk),
    .rst     (rst),
    .async_i (sdata_in),
    .level_o (s_sdata),
    .rise_o  (unused_sdata_rise),
    .fall_o  (unused_sdata_fall)
  );

  rx_state_e              state_q;
  logic [FRAME_BITS-1:0]  shadow_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [CFG_WIDTH-1:0]   cfg_q;
  logic                   cfg_valid_q, start_q, frame_error_q, busy_q;
  logic [SET_W-1:0]       settle_q;
  logic                   armed_q;
  logic                   frame_ok;

  // A frame is accepted only on exact length (and even parity when enabled)
`ifdef CFG_PARITY_EN
  assign frame_ok = (bit_cnt_q == CNT_FULL) && !(^shadow_q);
`else
  assign frame_ok = (bit_cnt_q == CNT_FULL);
`endif

  // Receiver FSM with registered outputs. armed_q blocks the sen "rise"
  // produced by a pin that was already high when reset released: it only
  // sets once the synchroniser has filled and sen is seen low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      bit_cnt_q     <= '0;
      cfg_q         <= '0;
      cfg_valid_q   <= 1'b0;
      start_q       <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
      settle_q      <= '0;
      armed_q       <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (settle_q != SETTLE_DONE) settle_q <= settle_q + 1'b1;
      else if (!s_sen)             armed_q  <= 1'b1;

      case (state_q)
        IDLE: begin
          if (sen_rise && armed_q) begin
            state_q   <= SHIFT;
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          // A clock edge coinciding with the end of frame is dropped
          if (sen_fall) begin
            state_q <= COMMIT;
            busy_q  <= 1'b0;
          end else if (sclk_rise && s_sen) begin
            shadow_q <= {s_sdata, shadow_q[FRAME_BITS-1:1]};
            if (bit_cnt_q != CNT_SAT) bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          if (frame_ok) begin
            cfg_q         <= shadow_q[CFG_WIDTH-1:0];
            cfg_valid_q   <= 1'b1;
            frame_error_q <= 1'b0;
            start_q       <= 1'b1;
          end else begin
            frame_error_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_out     = cfg_q;
  assign cfg_valid   = cfg_valid_q;
  assign start       = start_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cfg_serial_rx.sv
// Directed bench for cfg_serial_rx: good, short, long, parity and
// reset-interrupted frames, each scenario checked inline.
module tb_cfg_serial_rx;

`ifdef CFG_PARITY_EN
  localparam int FRAME_LEN = 58;
`else
  localparam int FRAME_LEN = 57;
`endif

  logic        clk = 1'b0;
  logic        rst, sen_in, sclk_in, sdata_in;
  logic [56:0] cfg_out;
  logic        cfg_valid, start, frame_error, busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Monitors sampled on the falling edge
  int          start_count = 0;
  int          cfg_changes = 0;
  bit          start_prev = 1'b0;
  bit          double_start = 1'b0;
  bit          busy_seen = 1'b0;
  logic [56:0] cfg_prev = '0;

  always #5 clk = ~clk;

  cfg_serial_rx #(.CFG_WIDTH(57), .SYNC_STAGES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .sen_in      (sen_in),
    .sclk_in     (sclk_in),
    .sdata_in    (sdata_in),
    .cfg_out     (cfg_out),
    .cfg_valid   (cfg_valid),
    .start       (start),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always @(negedge clk) begin
    if (start === 1'b1) start_count++;
    if (start === 1'b1 && start_prev) double_start = 1'b1;
    start_prev = (start === 1'b1);
    if (busy === 1'b1) busy_seen = 1'b1;
    if (cfg_out !== cfg_prev) cfg_changes++;
    cfg_prev = cfg_out;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    start_count  = 0;
    cfg_changes  = 0;
    double_start = 1'b0;
    busy_seen    = 1'b0;
  endtask

  // Frame bits as transmitted: payload, plus even parity when enabled
  function automatic logic [63:0] frame_bits(input logic [56:0] payload);
    logic [63:0] b;
    b = {7'd0, payload};
`ifdef CFG_PARITY_EN
    b[57] = ^payload;
`endif
    return b;
  endfunction

  task automatic frame_begin();
    sen_in  = 1'b1;
    sclk_in = 1'b0;
    wait_clks(6);
  endtask

  // LSB first, sclk half-period of 8 clk
  task automatic clock_bits(input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      sdata_in = (i < 64) ? bits[i] : 1'b0;
      sclk_in  = 1'b0;
      wait_clks(8);
      sclk_in  = 1'b1;
      wait_clks(8);
    end
  endtask

  task automatic frame_end();
    sclk_in = 1'b0;
    wait_clks(8);
    sen_in = 1'b0;
    wait_clks(16);
  endtask

  task automatic send_frame(input logic [63:0] bits, input int n);
    frame_begin();
    clock_bits(bits, n);
    frame_end();
    $display("[TB] frame bits=%0d data=%h -> cfg_out=%h valid=%0b err=%0b starts=%0d",
             n, bits, cfg_out, cfg_valid, frame_error, start_count);
  endtask

  task automatic test_reset();
    rst = 1'b1; sen_in = 1'b0; sclk_in = 1'b0; sdata_in = 1'b0;
    wait_clks(4);
    tests_run++; if (cfg_out !== 57'd0) begin tests_failed++; $display("FAIL reset_cfg_out: got %h expected 0", cfg_out); end
    tests_run++; if (cfg_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_cfg_valid: got %b expected 0", cfg_valid); end
    tests_run++; if (start !== 1'b0) begin tests_failed++; $display("FAIL reset_start: got %b expected 0", start); end
    tests_run++; if (frame_error !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    wait_clks(8);
    $display("[TB] reset released cfg_out=%h valid=%0b busy=%0b", cfg_out, cfg_valid, busy);
  endtask

  task automatic test_good_frame();
    clear_mon();
    send_frame(frame_bits(57'h1_2345_6789_ABCD), FRAME_LEN);
    tests_run++; if (cfg_out !== 57'h1_2345_6789_ABCD) begin tests_failed++; $display("FAIL good_cfg_out: got %h expected %h", cfg_out, 57'h1_2345_6789_ABCD); end
    tests_run++; if (cfg_valid !== 1'b1) begin tests_failed++; $display("FAIL good_cfg_valid: got %b expected 1", cfg_valid); end
    tests_run++; if (start_count != 1) begin tests_failed++; $display("FAIL good_start_count: got %0d expected 1", start_count); end
    tests_run++; if (frame_error !== 1'b0) begin tests_failed++; $display("FAIL good_frame_error: got %b expected 0", frame_error); end
    tests_run++; if (busy_seen !== 1'b1) begin tests_failed++; $display("FAIL good_busy_seen: got %b expected 1", busy_seen); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL good_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_short_frame();
    clear_mon();
    send_frame(frame_bits(57'h0_0000_1111_2222), FRAME_LEN - 1);
    tests_run++; if (cfg_out !== 57'h1_2345_6789_ABCD) begin tests_failed++; $display("FAIL short_cfg_out: got %h expected %h", cfg_out, 57'h1_2345_6789_ABCD); end
    tests_run++; if (frame_error !== 1'b1) begin tests_failed++; $display("FAIL short_frame_error: got %b expected 1", frame_error); end
    tests_run++; if (start_count != 0) begin tests_failed++; $display("FAIL short_start_count: got %0d expected 0", start_count); end
    tests_run++; if (cfg_changes != 0) begin tests_failed++; $display("FAIL short_cfg_changes: got %0d expected 0", cfg_changes); end
    tests_run++; if (cfg_valid !== 1'b1) begin tests_failed++; $display("FAIL short_cfg_valid: got %b expected 1", cfg_valid); end
    clear_mon();
    send_frame(frame_bits(57'h1_55AA_F00F_1234), FRAME_LEN);
    tests_run++; if (cfg_out !== 57'h1_55AA_F00F_1234) begin tests_failed++; $display("FAIL recover_cfg_out: got %h expected %h", cfg_out, 57'h1_55AA_F00F_1234); end
    tests_run++; if (frame_error !== 1'b0) begin tests_failed++; $display("FAIL recover_frame_error: got %b expected 0", frame_error); end
    tests_run++; if (start_count != 1) begin tests_failed++; $display("FAIL recover_start_count: got %0d expected 1", start_count); end
  endtask

  task automatic test_overflow();
    clear_mon();
    frame_begin();
    clock_bits(64'hFFFF_0000_FFFF_0000, FRAME_LEN + 3);
    sclk_in = 1'b0;
    wait_clks(8);
    tests_run++; if (dut.bit_cnt_q !== 6'(FRAME_LEN + 1)) begin tests_failed++; $display("FAIL overflow_bit_cnt: got %0d expected %0d", dut.bit_cnt_q, FRAME_LEN + 1); end
    frame_end();
    $display("[TB] frame bits=%0d (overflow) -> cfg_out=%h err=%0b starts=%0d", FRAME_LEN + 3, cfg_out, frame_error, start_count);
    tests_run++; if (frame_error !== 1'b1) begin tests_failed++; $display("FAIL overflow_frame_error: got %b expected 1", frame_error); end
    tests_run++; if (start_count != 0) begin tests_failed++; $display("FAIL overflow_start_count: got %0d expected 0", start_count); end
    tests_run++; if (cfg_out !== 57'h1_55AA_F00F_1234) begin tests_failed++; $display("FAIL overflow_cfg_out: got %h expected %h", cfg_out, 57'h1_55AA_F00F_1234); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    frame_begin();
    clock_bits(64'h3FFF_FFFF, 30);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    wait_clks(2);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    tests_run++; if (cfg_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_cfg_valid: got %b expected 0", cfg_valid); end
    frame_end();
    $display("[TB] frame bits=30 interrupted by reset -> cfg_out=%h starts=%0d", cfg_out, start_count);
    send_frame(frame_bits(57'h0AA), FRAME_LEN);
    tests_run++; if (cfg_out !== 57'h0AA) begin tests_failed++; $display("FAIL midrst_cfg_out: got %h expected %h", cfg_out, 57'h0AA); end
    tests_run++; if (start_count != 1) begin tests_failed++; $display("FAIL midrst_start_count: got %0d expected 1", start_count); end
  endtask

  task automatic test_sen_through_reset();
    clear_mon();
    rst = 1'b1;
    sen_in = 1'b1;
    sclk_in = 1'b0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(6);
    clock_bits(frame_bits(57'h0_DEAD_BEEF_0001), FRAME_LEN);
    frame_end();
    $display("[TB] frame bits=%0d sen high through reset -> cfg_out=%h valid=%0b starts=%0d",
             FRAME_LEN, cfg_out, cfg_valid, start_count);
    tests_run++; if (start_count != 0) begin tests_failed++; $display("FAIL senrst_first_starts: got %0d expected 0", start_count); end
    tests_run++; if (cfg_valid !== 1'b0) begin tests_failed++; $display("FAIL senrst_first_valid: got %b expected 0", cfg_valid); end
    send_frame(frame_bits(57'h0_0000_0BAD_CAFE), FRAME_LEN);
    tests_run++; if (cfg_out !== 57'h0_0000_0BAD_CAFE) begin tests_failed++; $display("FAIL senrst_cfg_out: got %h expected %h", cfg_out, 57'h0_0000_0BAD_CAFE); end
    tests_run++; if (start_count != 1) begin tests_failed++; $display("FAIL senrst_start_count: got %0d expected 1", start_count); end
    tests_run++; if (cfg_valid !== 1'b1) begin tests_failed++; $display("FAIL senrst_cfg_valid: got %b expected 1", cfg_valid); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(frame_bits(57'h0_1111_2222_3333), FRAME_LEN);
    send_frame(frame_bits(57'h1_4444_5555_6666), FRAME_LEN);
    tests_run++; if (cfg_out !== 57'h1_4444_5555_6666) begin tests_failed++; $display("FAIL b2b_cfg_out: got %h expected %h", cfg_out, 57'h1_4444_5555_6666); end
    tests_run++; if (start_count != 2) begin tests_failed++; $display("FAIL b2b_start_count: got %0d expected 2", start_count); end
    tests_run++; if (double_start !== 1'b0) begin tests_failed++; $display("FAIL b2b_double_start: got %b expected 0", double_start); end
    tests_run++; if (cfg_changes != 2) begin tests_failed++; $display("FAIL b2b_cfg_changes: got %0d expected 2", cfg_changes); end
  endtask

`ifdef CFG_PARITY_EN
  task automatic test_parity();
    logic [63:0] b;
    clear_mon();
    b = 64'h1 | (64'h1 << 57);
    send_frame(b, 58);
    tests_run++; if (cfg_out !== 57'h1) begin tests_failed++; $display("FAIL par_good_cfg_out: got %h expected 1", cfg_out); end
    tests_run++; if (start_count != 1) begin tests_failed++; $display("FAIL par_good_start_count: got %0d expected 1", start_count); end
    tests_run++; if (frame_error !== 1'b0) begin tests_failed++; $display("FAIL par_good_frame_error: got %b expected 0", frame_error); end
    send_frame(frame_bits(57'h0_0000_0000_0F0F), 58);
    clear_mon();
    b = 64'h1;
    send_frame(b, 58);
    tests_run++; if (cfg_out !== 57'h0F0F) begin tests_failed++; $display("FAIL par_bad_cfg_out: got %h expected %h", cfg_out, 57'h0F0F); end
    tests_run++; if (frame_error !== 1'b1) begin tests_failed++; $display("FAIL par_bad_frame_error: got %b expected 1", frame_error); end
    tests_run++; if (start_count != 0) begin tests_failed++; $display("FAIL par_bad_start_count: got %0d expected 0", start_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_short_frame();
    test_overflow();
    test_reset_mid_frame();
    test_sen_through_reset();
    test_back_to_back();
`ifdef CFG_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
